// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and constants for the two-port RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    // Bytes per RAM word; the low address bits below this are byte offsets.
    localparam int WORD_BYTES  = 4;
    localparam int c_BYTE_BITS = $clog2(WORD_BYTES);

    // Owner encoding carried in the response slot.
    localparam logic c_OWNER_I = 1'b0;
    localparam logic c_OWNER_D = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

    // One in-flight response: does it exist, who gets it, was it out of window.
    typedef struct packed {
        logic valid;
        logic owner;
        logic err;
    } rsp_slot_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input grant generator. Round-robin on a tie when RR_EN=1,
//               otherwise fixed priority with the dbus winning ties.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import ram_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic   CLK,
    input  logic   RST,
    input  logic   i_valid_i,
    input  logic   i_valid_d,
    output grant_t o_grant
);

    // 1 = dbus was granted most recently. Resets to 1 so ibus wins the first tie.
    logic r_last_d;

    // Grant is purely combinational from the requests and the history bit.
    always_comb begin
        o_grant = GNT_NONE;
        if (i_valid_i && i_valid_d) begin
            if (RR_EN && r_last_d) begin
                o_grant = GNT_I;
            end else begin
                o_grant = GNT_D;
            end
        end else if (i_valid_i) begin
            o_grant = GNT_I;
        end else if (i_valid_d) begin
            o_grant = GNT_D;
        end
    end

    // Every grant is an accept (READY == grant), so record the winner each time.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_last_d <= 1'b1;
        end else if (o_grant != GNT_NONE) begin
            r_last_d <= (o_grant == GNT_D);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter_2p.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_2p
// Description : Arbitrates the CPU ibus (read-only) and dbus (read/write) onto
//               a single-port byte-masked RAM with a one-cycle registered
//               read, and routes each read result back to its owner.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter_2p
    import ram_arb_pkg::*;
#(
    parameter int          ADR_W     = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          RR_EN     = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,

    input  logic             I_REQ_VALID,
    output logic             I_REQ_READY,
    input  logic [31:0]      I_REQ_ADDR,
    output logic             I_RSP_VALID,
    output logic [31:0]      I_RSP_DATA,
    output logic             I_RSP_ERR,

    input  logic             D_REQ_VALID,
    output logic             D_REQ_READY,
    input  logic             D_REQ_WE,
    input  logic [31:0]      D_REQ_ADDR,
    input  logic [31:0]      D_REQ_WDATA,
    input  logic [3:0]       D_REQ_MASK,
    output logic             D_RSP_VALID,
    output logic [31:0]      D_RSP_DATA,
    output logic             D_RSP_ERR,

    output logic [ADR_W-1:0] RAM_ADR,
    output logic [31:0]      RAM_D,
    output logic [3:0]       RAM_WEM,
    output logic             RAM_WE,
    output logic             RAM_ME,
    output logic             RAM_OE,
    input  logic [31:0]      RAM_Q
);

    localparam int c_WIN_LSB = ADR_W + c_BYTE_BITS;

    grant_t    w_grant;
    logic      w_arb_vi;
    logic      w_arb_vd;
    logic      w_accept;
    logic      w_sel_d;
    logic      w_is_write;
    logic      w_in_win;
    logic      w_ram_go;
    logic      w_unused;
    logic [31:0] w_addr;
    rsp_slot_t w_slot_nxt;
    rsp_slot_t r_slot;
    logic      w_rsp_i;
    logic      w_rsp_d;

    // Nothing is granted while reset is held, so no RAM write can slip through.
    assign w_arb_vi = I_REQ_VALID & ~RST;
    assign w_arb_vd = D_REQ_VALID & ~RST;

    rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .CLK       (CLK),
        .RST       (RST),
        .i_valid_i (w_arb_vi),
        .i_valid_d (w_arb_vd),
        .o_grant   (w_grant)
    );

    assign I_REQ_READY = (w_grant == GNT_I);
    assign D_REQ_READY = (w_grant == GNT_D);

    // Request decode for whichever side won this cycle.
    always_comb begin
        w_accept   = (w_grant != GNT_NONE);
        w_sel_d    = (w_grant == GNT_D);
        w_addr     = w_sel_d ? D_REQ_ADDR : I_REQ_ADDR;
        w_is_write = w_sel_d & D_REQ_WE;
        w_in_win   = (w_addr[31:c_WIN_LSB] == BASE_ADDR[31:c_WIN_LSB]);
        w_ram_go   = w_accept & w_in_win;
    end

    // Byte offset within the word is irrelevant to a word-wide RAM.
    assign w_unused = &{1'b0, w_addr[c_BYTE_BITS-1:0]};

    // RAM pin drive; enables are forced low on idle and out-of-window cycles.
    always_comb begin
        RAM_ADR = w_addr[c_WIN_LSB-1:c_BYTE_BITS];
        RAM_D   = D_REQ_WDATA;
        RAM_ME  = w_ram_go;
        RAM_WE  = w_ram_go & w_is_write;
        RAM_WEM = (w_ram_go & w_is_write) ? D_REQ_MASK : 4'b0000;
        RAM_OE  = 1'b1;
    end

    // A response is owed for every read and for every rejected (error) access;
    // in-window writes complete silently.
    always_comb begin
        w_slot_nxt.valid = w_accept & ~(w_is_write & w_in_win);
        w_slot_nxt.owner = w_sel_d ? c_OWNER_D : c_OWNER_I;
        w_slot_nxt.err   = ~w_in_win;
    end

    // Single response stage aligned with the RAM's registered read output.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_slot <= '0;
        end else begin
            r_slot <= w_slot_nxt;
        end
    end

    // Steer the slot (and RAM_Q) to its owner; error responses return zero data.
    always_comb begin
        w_rsp_i     = r_slot.valid & (r_slot.owner == c_OWNER_I);
        w_rsp_d     = r_slot.valid & (r_slot.owner == c_OWNER_D);
        I_RSP_VALID = w_rsp_i;
        I_RSP_ERR   = w_rsp_i & r_slot.err;
        I_RSP_DATA  = (w_rsp_i & ~r_slot.err) ? RAM_Q : 32'h0;
        D_RSP_VALID = w_rsp_d;
        D_RSP_ERR   = w_rsp_d & r_slot.err;
        D_RSP_DATA  = (w_rsp_d & ~r_slot.err) ? RAM_Q : 32'h0;
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter_2p.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter_2p
// Description : Directed self-checking bench for ram_arbiter_2p with a
//               behavioural RAM and a response scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter_2p;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, d_req_valid, d_req_we;
    logic [31:0] i_req_addr, d_req_addr, d_req_wdata;
    logic [3:0]  d_req_mask;
    logic        i_req_ready, i_rsp_valid, i_rsp_err;
    logic [31:0] i_rsp_data;
    logic        d_req_ready, d_rsp_valid, d_rsp_err;
    logic [31:0] d_rsp_data;
    logic [11:0] ram_adr;
    logic [31:0] ram_d, ram_q;
    logic [3:0]  ram_wem;
    logic        ram_we, ram_me, ram_oe;

    // Fixed-priority instance: only its READY outputs are checked.
    logic        fp_i_ready, fp_d_ready, fp_i_rv, fp_i_re, fp_d_rv, fp_d_re;
    logic [31:0] fp_i_rd, fp_d_rd, fp_ram_d;
    logic [11:0] fp_ram_adr;
    logic [3:0]  fp_ram_wem;
    logic        fp_ram_we, fp_ram_me, fp_ram_oe;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic        iv;
        logic        dv;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    ram_arbiter_2p #(.ADR_W(12), .BASE_ADDR(32'h0), .RR_EN(1'b1)) dut (
        .CLK(clk), .RST(rst),
        .I_REQ_VALID(i_req_valid), .I_REQ_READY(i_req_ready), .I_REQ_ADDR(i_req_addr),
        .I_RSP_VALID(i_rsp_valid), .I_RSP_DATA(i_rsp_data), .I_RSP_ERR(i_rsp_err),
        .D_REQ_VALID(d_req_valid), .D_REQ_READY(d_req_ready), .D_REQ_WE(d_req_we),
        .D_REQ_ADDR(d_req_addr), .D_REQ_WDATA(d_req_wdata), .D_REQ_MASK(d_req_mask),
        .D_RSP_VALID(d_rsp_valid), .D_RSP_DATA(d_rsp_data), .D_RSP_ERR(d_rsp_err),
        .RAM_ADR(ram_adr), .RAM_D(ram_d), .RAM_WEM(ram_wem), .RAM_WE(ram_we),
        .RAM_ME(ram_me), .RAM_OE(ram_oe), .RAM_Q(ram_q)
    );

    ram_arbiter_2p #(.ADR_W(12), .BASE_ADDR(32'h0), .RR_EN(1'b0)) dut_fp (
        .CLK(clk), .RST(rst),
        .I_REQ_VALID(i_req_valid), .I_REQ_READY(fp_i_ready), .I_REQ_ADDR(i_req_addr),
        .I_RSP_VALID(fp_i_rv), .I_RSP_DATA(fp_i_rd), .I_RSP_ERR(fp_i_re),
        .D_REQ_VALID(d_req_valid), .D_REQ_READY(fp_d_ready), .D_REQ_WE(d_req_we),
        .D_REQ_ADDR(d_req_addr), .D_REQ_WDATA(d_req_wdata), .D_REQ_MASK(d_req_mask),
        .D_RSP_VALID(fp_d_rv), .D_RSP_DATA(fp_d_rd), .D_RSP_ERR(fp_d_re),
        .RAM_ADR(fp_ram_adr), .RAM_D(fp_ram_d), .RAM_WEM(fp_ram_wem), .RAM_WE(fp_ram_we),
        .RAM_ME(fp_ram_me), .RAM_OE(fp_ram_oe), .RAM_Q(ram_q)
    );

    // Behavioural single-port RAM: masked write, registered read.
    always @(posedge clk) begin
        if (ram_me) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wem[b]) mem[ram_adr][8*b +: 8] <= ram_d[8*b +: 8];
                end
            end else begin
                ram_q <= mem[ram_adr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".i_rsp_valid"}, {31'b0, i_rsp_valid}, 32'd0);
        chk({tag, ".d_rsp_valid"}, {31'b0, d_rsp_valid}, 32'd0);
        chk({tag, ".i_rsp_err"},   {31'b0, i_rsp_err},   32'd0);
        chk({tag, ".d_rsp_err"},   {31'b0, d_rsp_err},   32'd0);
        chk({tag, ".i_rsp_data"},  i_rsp_data,           32'd0);
        chk({tag, ".d_rsp_data"},  d_rsp_data,           32'd0);
        chk({tag, ".ram_me"},      {31'b0, ram_me},      32'd0);
        chk({tag, ".ram_we"},      {31'b0, ram_we},      32'd0);
        chk({tag, ".ram_wem"},     {28'b0, ram_wem},     32'd0);
        chk({tag, ".ram_oe"},      {31'b0, ram_oe},      32'd1);
    endtask

    // One clock of stimulus: drive, check grant and RAM pins, push the expected
    // response, clock, then pop and compare what the DUT returns.
    // g: 0 = none, 1 = ibus, 2 = dbus.
    task automatic cycle(input string tag,
                         input logic iv, input logic [31:0] ia,
                         input logic dv, input logic dwe, input logic [31:0] da,
                         input logic [31:0] dwd, input logic [3:0] dm,
                         input int g, input logic me, input logic [11:0] adr,
                         input logic we, input logic [3:0] wem,
                         input logic ri, input logic rd, input logic err,
                         input logic [31:0] data);
        exp_t e;
        i_req_valid = iv;  i_req_addr = ia;
        d_req_valid = dv;  d_req_we = dwe; d_req_addr = da;
        d_req_wdata = dwd; d_req_mask = dm;
        #1;
        chk({tag, ".i_ready"}, {31'b0, i_req_ready}, {31'b0, g == 1});
        chk({tag, ".d_ready"}, {31'b0, d_req_ready}, {31'b0, g == 2});
        chk({tag, ".ram_me"},  {31'b0, ram_me},  {31'b0, me});
        if (me) chk({tag, ".ram_adr"}, {20'b0, ram_adr}, {20'b0, adr});
        chk({tag, ".ram_we"},  {31'b0, ram_we},  {31'b0, we});
        chk({tag, ".ram_wem"}, {28'b0, ram_wem}, {28'b0, wem});
        chk({tag, ".fp_i_ready"}, {31'b0, fp_i_ready}, {31'b0, iv & ~dv});
        chk({tag, ".fp_d_ready"}, {31'b0, fp_d_ready}, {31'b0, dv});
        e.iv = ri; e.dv = rd; e.err = err; e.data = data;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".i_rsp_valid"}, {31'b0, i_rsp_valid}, {31'b0, e.iv});
            chk({tag, ".d_rsp_valid"}, {31'b0, d_rsp_valid}, {31'b0, e.dv});
            if (e.iv) begin
                chk({tag, ".i_rsp_err"},  {31'b0, i_rsp_err}, {31'b0, e.err});
                chk({tag, ".i_rsp_data"}, i_rsp_data, e.data);
            end
            if (e.dv) begin
                chk({tag, ".d_rsp_err"},  {31'b0, d_rsp_err}, {31'b0, e.err});
                chk({tag, ".d_rsp_data"}, d_rsp_data, e.data);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 32'h0;
        mem[2]    = 32'hAAAA_AAAA;
        mem[4]    = 32'hDEAD_BEEF;
        mem[5]    = 32'h0505_0505;
        mem[4095] = 32'h5A5A_A5A5;
        for (int k = 0; k < 6; k++) begin
            mem[16 + k] = 32'hC0DE_0000 + k;
            mem[32 + k] = 32'hD000_0000 + k;
        end
        ram_q = 32'h0;

        rst = 1'b1;
        i_req_valid = 1'b0; i_req_addr = 32'h0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = 32'h0;
        d_req_wdata = 32'h0; d_req_mask = 4'h0;
        #1;
        chk_reset_values("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // ibus read of word 4
        cycle("ird",  1, 32'h10, 0, 0, 32'h0, 32'h0, 4'h0,
              1, 1, 12'd4, 0, 4'h0, 1, 0, 0, 32'hDEAD_BEEF);
        // masked dbus write then read-back of word 2
        cycle("dwr",  0, 32'h0, 1, 1, 32'h8, 32'h1122_3344, 4'b0101,
              2, 1, 12'd2, 1, 4'b0101, 0, 0, 0, 32'h0);
        cycle("drd",  0, 32'h0, 1, 0, 32'h8, 32'h0, 4'h0,
              2, 1, 12'd2, 0, 4'h0, 0, 1, 0, 32'hAA22_AA44);

        // Both requesting for six cycles: dbus won last, so ibus leads.
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0)
                cycle("rr_i", 1, 32'h40 + 4*k, 1, 0, 32'h80 + 4*k, 32'h0, 4'h0,
                      1, 1, 12'(16 + k), 0, 4'h0, 1, 0, 0, 32'hC0DE_0000 + k);
            else
                cycle("rr_d", 1, 32'h40 + 4*k, 1, 0, 32'h80 + 4*k, 32'h0, 4'h0,
                      2, 1, 12'(32 + k), 0, 4'h0, 0, 1, 0, 32'hD000_0000 + k);
        end

        // Out-of-window dbus read and write
        cycle("doow", 0, 32'h0, 1, 0, 32'h0001_0000, 32'h0, 4'h0,
              2, 0, 12'd0, 0, 4'h0, 0, 1, 1, 32'h0);
        cycle("dwoow", 0, 32'h0, 1, 1, 32'h2000_0000, 32'hFFFF_FFFF, 4'hF,
              2, 0, 12'd0, 0, 4'h0, 0, 1, 1, 32'h0);
        // Last word of the window, then first byte past it
        cycle("dtop", 0, 32'h0, 1, 0, 32'h3FFC, 32'h0, 4'h0,
              2, 1, 12'd4095, 0, 4'h0, 0, 1, 0, 32'h5A5A_A5A5);
        cycle("ioow", 1, 32'h4000, 0, 0, 32'h0, 32'h0, 4'h0,
              1, 0, 12'd0, 0, 4'h0, 1, 0, 1, 32'h0);
        // Zero-mask write leaves word 4 intact; unaligned byte address ignored
        cycle("dm0",  0, 32'h0, 1, 1, 32'h10, 32'hFFFF_FFFF, 4'h0,
              2, 1, 12'd4, 1, 4'h0, 0, 0, 0, 32'h0);
        cycle("iun",  1, 32'h13, 0, 0, 32'h0, 32'h0, 4'h0,
              1, 1, 12'd4, 0, 4'h0, 1, 0, 0, 32'hDEAD_BEEF);
        cycle("idle", 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0,
              0, 0, 12'd0, 0, 4'h0, 0, 0, 0, 32'h0);

        // Accept an ibus read, then reset in the following cycle.
        i_req_valid = 1'b1; i_req_addr = 32'h10;
        #1;
        chk("rst_acc.i_ready", {31'b0, i_req_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        i_req_valid = 1'b0;
        #1;
        chk_reset_values("rst_mid");
        @(posedge clk); #1;
        chk_reset_values("rst_hold");
        rst = 1'b0;

        // First tie after reset goes to ibus
        cycle("tie",  1, 32'h14, 1, 0, 32'h18, 32'h0, 4'h0,
              1, 1, 12'd5, 0, 4'h0, 1, 0, 0, 32'h0505_0505);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
